// File: rtl/e203_commit_monitor.sv
// Commit-stream test monitor: RUN/DRAIN/DONE sequencing, cycle and instruction
// counters, and per-channel PC watch hit counters with first-hit timestamps.

module e203_commit_watch_ch #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             act_i,
  input  logic             cmt_valid_i,
  input  logic [PC_W-1:0]  cmt_pc_i,
  input  logic [PC_W-1:0]  watch_pc_i,
  input  logic [CNT_W-1:0] cyc_i,
  output logic             first_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] first_cyc_o,
  output logic             first_vld_o
);
  logic             hit;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, first_cyc_q, first_cyc_d;
  logic             first_vld_q, first_vld_d;

  assign hit     = act_i && cmt_valid_i && (cmt_pc_i == watch_pc_i);
  assign first_o = hit && !first_vld_q;

  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    first_cyc_d = first_cyc_q;
    first_vld_d = first_vld_q;
    if (clr_i) begin
      hit_cnt_d   = '0;
      first_cyc_d = '0;
      first_vld_d = 1'b0;
    end else begin
      if (hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      if (first_o) begin
        first_cyc_d = cyc_i;
        first_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      first_cyc_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      first_cyc_q <= first_cyc_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign hit_cnt_o   = hit_cnt_q;
  assign first_cyc_o = first_cyc_q;
  assign first_vld_o = first_vld_q;
endmodule

module e203_commit_monitor #(
  parameter int          PC_W        = 32,
  parameter int          CNT_W       = 32,
  parameter int          NUM_WATCH   = 4,
  parameter int          END_CH      = 0,
  parameter logic [31:0] PASS_SIG    = 32'hdeadbeef,
  parameter int          DRAIN_CYC   = 8,
  parameter int          TIMEOUT_CYC = 10000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_WATCH*PC_W-1:0] watch_pc,
  input  logic                      cmt_valid,
  input  logic [PC_W-1:0]           cmt_pc,
  input  logic                      ir_valid,
  input  logic                      ir_ready,
  input  logic [31:0]               sig_val,
  input  logic [3:0]                rd_idx,
  output logic [CNT_W-1:0]          rd_hit_cnt,
  output logic [CNT_W-1:0]          rd_first_cyc,
  output logic                      rd_first_vld,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          instr_cnt,
  output logic [CNT_W-1:0]          end_cyc,
  output logic                      end_seen,
  output logic [1:0]                state,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  localparam int               DRN_W    = $clog2(DRAIN_CYC) + 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);
  localparam logic [63:0]      TO_LAST  = 64'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, ins_q, ins_d, end_cyc_q, end_cyc_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               end_seen_q, end_seen_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic               clr, act, to_hit;

  logic [NUM_WATCH-1:0]            ch_first, ch_vld;
  logic [NUM_WATCH-1:0][CNT_W-1:0] ch_hit, ch_fcyc;

  // start only restarts from an idle/finished run; it is ignored while testing
  assign clr    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign act    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign to_hit = (64'(cyc_q) == TO_LAST);

  for (genvar i = 0; i < NUM_WATCH; i++) begin : g_ch
    e203_commit_watch_ch #(.PC_W(PC_W), .CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr),
      .act_i       (act),
      .cmt_valid_i (cmt_valid),
      .cmt_pc_i    (cmt_pc),
      .watch_pc_i  (watch_pc[i*PC_W +: PC_W]),
      .cyc_i       (cyc_q),
      .first_o     (ch_first[i]),
      .hit_cnt_o   (ch_hit[i]),
      .first_cyc_o (ch_fcyc[i]),
      .first_vld_o (ch_vld[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    ins_d      = ins_q;
    end_seen_d = end_seen_q;
    end_cyc_d  = end_cyc_q;
    done_d     = done_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    drn_d      = '0;
    if (act && cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
    if (state_q == S_RUN && ir_valid && ir_ready && !end_seen_q && ins_q != '1)
      ins_d = ins_q + CNT_W'(1);
    if (ch_first[END_CH]) begin
      end_seen_d = 1'b1;
      end_cyc_d  = cyc_q;
    end
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN: begin
        // signature match takes priority over a coincident timeout
        if (sig_val == PASS_SIG) state_d = S_DRAIN;
        else if (to_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + DRN_W'(1);
        if (drn_q == DRN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
          tmo_d   = 1'b0;
        end
      end
      default: ;
    endcase
    if (clr) begin
      cyc_d      = '0;
      ins_d      = '0;
      end_seen_d = 1'b0;
      end_cyc_d  = '0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      tmo_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      ins_q      <= '0;
      end_seen_q <= 1'b0;
      end_cyc_q  <= '0;
      drn_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      ins_q      <= ins_d;
      end_seen_q <= end_seen_d;
      end_cyc_q  <= end_cyc_d;
      drn_q      <= drn_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    rd_hit_cnt   = '0;
    rd_first_cyc = '0;
    rd_first_vld = 1'b0;
    for (int i = 0; i < NUM_WATCH; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_hit_cnt   = ch_hit[i];
        rd_first_cyc = ch_fcyc[i];
        rd_first_vld = ch_vld[i];
      end
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
  assign end_cyc   = end_cyc_q;
  assign end_seen  = end_seen_q;
  assign state     = state_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = tmo_q;
endmodule
